// File: rtl/llc_req_scheduler.sv
// Request scheduler in front of the LLC. CPU and snoop commands are buffered in
// per-source FIFOs and issued one at a time, snoop-first, with a CPU starvation guard.

module llc_req_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // The extra pointer MSB tells a full FIFO from an empty one once the index wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

module llc_req_scheduler #(
    parameter int CMDSIZE      = 4,
    parameter int ADDR_BITS    = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_valid,
    output logic                 cpu_ready,
    input  logic [CMDSIZE-1:0]   cpu_cmd,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic                 snp_valid,
    output logic                 snp_ready,
    input  logic [CMDSIZE-1:0]   snp_cmd,
    input  logic [ADDR_BITS-1:0] snp_addr,
    output logic                 llc_valid,
    input  logic                 llc_ready,
    output logic [CMDSIZE-1:0]   llc_cmd,
    output logic [ADDR_BITS-1:0] llc_addr,
    output logic                 llc_src,
    input  logic                 llc_done,
    output logic                 cmd_err,
    output logic [31:0]          issued_cnt
);
    localparam int EW = CMDSIZE + ADDR_BITS;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STEP_ONE = SW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic          cpu_full;
    logic          cpu_empty;
    logic          snp_full;
    logic          snp_empty;
    logic          cpu_ok;
    logic          snp_ok;
    logic          cpu_acc;
    logic          snp_acc;
    logic          cpu_pop;
    logic          snp_pop;
    logic [EW-1:0] cpu_head;
    logic [EW-1:0] snp_head;
    logic [SW-1:0] starve_cnt;

    function automatic logic cpu_code_legal(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(0)) || (c == CMDSIZE'(1)) || (c == CMDSIZE'(2)) ||
               (c == CMDSIZE'(8)) || (c == CMDSIZE'(9));
    endfunction

    function automatic logic snp_code_legal(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(3)) || (c == CMDSIZE'(4)) || (c == CMDSIZE'(5)) ||
               (c == CMDSIZE'(6));
    endfunction

    // Illegal commands still complete their handshake; they are just never enqueued.
    assign cpu_ready = !cpu_full;
    assign snp_ready = !snp_full;
    assign cpu_acc   = cpu_valid && cpu_ready;
    assign snp_acc   = snp_valid && snp_ready;
    assign cpu_ok    = cpu_code_legal(cpu_cmd);
    assign snp_ok    = snp_code_legal(snp_cmd);

    llc_req_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_cpu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cpu_acc && cpu_ok),
        .wdata ({cpu_cmd, cpu_addr}),
        .pop   (cpu_pop),
        .rdata (cpu_head),
        .full  (cpu_full),
        .empty (cpu_empty)
    );

    llc_req_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_snp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (snp_acc && snp_ok),
        .wdata ({snp_cmd, snp_addr}),
        .pop   (snp_pop),
        .rdata (snp_head),
        .full  (snp_full),
        .empty (snp_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!cpu_empty || !snp_empty) state_next = ISSUE;
            ISSUE:   if (llc_ready) state_next = WAIT;
            WAIT:    if (llc_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snoop wins a tie unless the CPU has already been passed over STARVE_LIMIT times.
    always_comb begin
        cpu_pop = 1'b0;
        snp_pop = 1'b0;
        if (state == IDLE) begin
            if (!snp_empty && (cpu_empty || (starve_cnt != LIMIT))) begin
                snp_pop = 1'b1;
            end else if (!cpu_empty) begin
                cpu_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            llc_valid <= 1'b0;
            llc_cmd   <= '0;
            llc_addr  <= '0;
            llc_src   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            llc_valid <= (state_next == ISSUE);
            cmd_err   <= (cpu_acc && !cpu_ok) || (snp_acc && !snp_ok);
            if (snp_pop) begin
                llc_cmd  <= snp_head[EW-1 -: CMDSIZE];
                llc_addr <= snp_head[ADDR_BITS-1:0];
                llc_src  <= 1'b1;
            end else if (cpu_pop) begin
                llc_cmd  <= cpu_head[EW-1 -: CMDSIZE];
                llc_addr <= cpu_head[ADDR_BITS-1:0];
                llc_src  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (cpu_empty || cpu_pop) begin
            starve_cnt <= '0;
        end else if (snp_pop && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + STEP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
        end else if ((state == WAIT) && llc_done) begin
            issued_cnt <= issued_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_llc_req_scheduler.sv
// Bench for llc_req_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the scheduler.

module tb_llc_req_scheduler;
    localparam int CMDSIZE   = 4;
    localparam int ADDR_BITS = 32;
    localparam int DEPTH     = 4;
    localparam int LIMIT     = 3;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 cpu_valid = 1'b0;
    logic                 cpu_ready;
    logic [CMDSIZE-1:0]   cpu_cmd = '0;
    logic [ADDR_BITS-1:0] cpu_addr = '0;
    logic                 snp_valid = 1'b0;
    logic                 snp_ready;
    logic [CMDSIZE-1:0]   snp_cmd = '0;
    logic [ADDR_BITS-1:0] snp_addr = '0;
    logic                 llc_valid;
    logic                 llc_ready = 1'b0;
    logic [CMDSIZE-1:0]   llc_cmd;
    logic [ADDR_BITS-1:0] llc_addr;
    logic                 llc_src;
    logic                 llc_done = 1'b0;
    logic                 cmd_err;
    logic [31:0]          issued_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [CMDSIZE-1:0]   cmd;
        logic [ADDR_BITS-1:0] addr;
    } req_t;

    req_t        mcq[$];
    req_t        msq[$];
    bit          m_presenting;
    bit          m_awaiting;
    int          m_starve;
    logic [31:0] m_done_cnt;
    logic        m_err;
    req_t        m_out;
    logic        m_src;

    logic        dut_src[$];
    logic [31:0] dut_addr[$];
    int          err_pulses;

    always #5 clk = ~clk;

    llc_req_scheduler #(
        .CMDSIZE      (CMDSIZE),
        .ADDR_BITS    (ADDR_BITS),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_cmd    (cpu_cmd),
        .cpu_addr   (cpu_addr),
        .snp_valid  (snp_valid),
        .snp_ready  (snp_ready),
        .snp_cmd    (snp_cmd),
        .snp_addr   (snp_addr),
        .llc_valid  (llc_valid),
        .llc_ready  (llc_ready),
        .llc_cmd    (llc_cmd),
        .llc_addr   (llc_addr),
        .llc_src    (llc_src),
        .llc_done   (llc_done),
        .cmd_err    (cmd_err),
        .issued_cnt (issued_cnt)
    );

    function automatic bit cpu_code_ok(input logic [CMDSIZE-1:0] c);
        return c inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    endfunction

    function automatic bit snp_code_ok(input logic [CMDSIZE-1:0] c);
        return c inside {4'd3, 4'd4, 4'd5, 4'd6};
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        mcq.delete();
        msq.delete();
        m_presenting = 1'b0;
        m_awaiting   = 1'b0;
        m_starve     = 0;
        m_done_cnt   = '0;
        m_err        = 1'b0;
        m_out        = '0;
        m_src        = 1'b0;
    endtask

    // One clock of the scheduler's rules, applied to the inputs about to be sampled.
    task automatic modelStep();
        bit c_acc;
        bit s_acc;
        bit cpu_was_empty;
        bit gave_cpu;
        bit gave_snp;
        c_acc         = cpu_valid && (mcq.size() < DEPTH);
        s_acc         = snp_valid && (msq.size() < DEPTH);
        m_err         = (c_acc && !cpu_code_ok(cpu_cmd)) || (s_acc && !snp_code_ok(snp_cmd));
        cpu_was_empty = (mcq.size() == 0);
        gave_cpu      = 1'b0;
        gave_snp      = 1'b0;
        if (!m_presenting && !m_awaiting) begin
            if (msq.size() != 0 && (cpu_was_empty || m_starve != LIMIT)) begin
                m_out        = msq.pop_front();
                m_src        = 1'b1;
                gave_snp     = 1'b1;
                m_presenting = 1'b1;
            end else if (!cpu_was_empty) begin
                m_out        = mcq.pop_front();
                m_src        = 1'b0;
                gave_cpu     = 1'b1;
                m_presenting = 1'b1;
            end
        end else if (m_presenting) begin
            if (llc_ready) begin
                m_presenting = 1'b0;
                m_awaiting   = 1'b1;
            end
        end else if (llc_done) begin
            m_awaiting = 1'b0;
            m_done_cnt = m_done_cnt + 32'd1;
        end
        if (cpu_was_empty || gave_cpu) begin
            m_starve = 0;
        end else if (gave_snp && m_starve < LIMIT) begin
            m_starve++;
        end
        if (c_acc && cpu_code_ok(cpu_cmd)) mcq.push_back(req_t'({cpu_cmd, cpu_addr}));
        if (s_acc && snp_code_ok(snp_cmd)) msq.push_back(req_t'({snp_cmd, snp_addr}));
    endtask

    task automatic checkOutput();
        compare("llc_valid", 32'(llc_valid), 32'(m_presenting));
        compare("llc_cmd", 32'(llc_cmd), 32'(m_out.cmd));
        compare("llc_addr", llc_addr, m_out.addr);
        compare("llc_src", 32'(llc_src), 32'(m_src));
        compare("issued_cnt", issued_cnt, m_done_cnt);
        compare("cmd_err", 32'(cmd_err), 32'(m_err));
        compare("cpu_ready", 32'(cpu_ready), 32'(mcq.size() < DEPTH));
        compare("snp_ready", 32'(snp_ready), 32'(msq.size() < DEPTH));
        if (cmd_err === 1'b1) err_pulses++;
    endtask

    task automatic applyStimulus(input logic cv, input logic [3:0] cc, input logic [31:0] ca,
                                 input logic sv, input logic [3:0] sc, input logic [31:0] sa,
                                 input logic lr, input logic ld);
        cpu_valid = cv;
        cpu_cmd   = cc;
        cpu_addr  = ca;
        snp_valid = sv;
        snp_cmd   = sc;
        snp_addr  = sa;
        llc_ready = lr;
        llc_done  = ld;
        if (llc_valid === 1'b1 && lr) begin
            dut_src.push_back(llc_src);
            dut_addr.push_back(llc_addr);
        end
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleTick(input logic lr, input logic ld);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, lr, ld);
    endtask

    task automatic doReset(input int pre_delay);
        #(pre_delay);
        cpu_valid = 1'b0;
        snp_valid = 1'b0;
        llc_ready = 1'b0;
        llc_done  = 1'b0;
        rst_n     = 1'b0;
        modelReset();
        #1;
        checkOutput();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        rst_n = 1'b1;
    endtask

    initial begin
        logic exp_order [8];
        logic [31:0] exp_addr [9];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_addr  = '{32'hA000, 32'hB000, 32'hB001, 32'hB002, 32'hB003,
                      32'hC000, 32'hC001, 32'hC002, 32'hC003};
        err_pulses = 0;

        doReset(2);

        // Single CPU read: llc_valid two edges after the push.
        applyStimulus(1'b1, 4'd0, 32'h1000_0040, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        compare("lat_push_edge_valid", 32'(llc_valid), 32'd0);
        idleTick(1'b0, 1'b0);
        compare("lat_valid", 32'(llc_valid), 32'd1);
        compare("lat_src", 32'(llc_src), 32'd0);
        compare("lat_addr", llc_addr, 32'h1000_0040);
        idleTick(1'b1, 1'b0);
        idleTick(1'b0, 1'b1);
        compare("single_cnt", issued_cnt, 32'd1);

        // Snoop priority with the CPU starvation guard.
        dut_src.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd1, 32'h100 + i, 1'b1, 4'd4, 32'h200 + i, 1'b0, 1'b0);
        end
        repeat (30) idleTick(1'b1, 1'b1);
        compare("order_len", dut_src.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < dut_src.size()) compare("order_src", 32'(dut_src[k]), 32'(exp_order[k]));
        end

        // Full FIFO, rejected fifth push, and ordering across the pointer wrap.
        dut_addr.delete();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hA000, 1'b0, 1'b0);
        idleTick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd2, 32'hB000 + i, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        end
        compare("full_ready", 32'(cpu_ready), 32'd0);
        applyStimulus(1'b1, 4'd2, 32'hBEEF, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        compare("full_ready_hold", 32'(cpu_ready), 32'd0);
        repeat (20) idleTick(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd2, 32'hC000 + i, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        end
        repeat (16) idleTick(1'b1, 1'b1);
        compare("wrap_len", dut_addr.size(), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < dut_addr.size()) compare("wrap_addr", dut_addr[k], exp_addr[k]);
        end

        // Illegal codes: one pulse each, including a single pulse for a double drop.
        err_pulses = 0;
        applyStimulus(1'b1, 4'd3, 32'h1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        idleTick(1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'h2, 1'b0, 1'b0);
        idleTick(1'b0, 1'b0);
        applyStimulus(1'b1, 4'd7, 32'h3, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        idleTick(1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 32'h4, 1'b1, 4'd0, 32'h5, 1'b0, 1'b0);
        compare("err_double_pulse", 32'(cmd_err), 32'd1);
        idleTick(1'b0, 1'b0);
        idleTick(1'b0, 1'b0);
        compare("err_pulses", err_pulses, 32'd4);
        compare("illegal_no_issue", 32'(llc_valid), 32'd0);
        compare("illegal_cnt", issued_cnt, 32'd18);

        // Back-pressure with a stray done while the command is still presented.
        applyStimulus(1'b1, 4'd8, 32'hD00D_0008, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        idleTick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idleTick(1'b0, (i == 4));
            compare("bp_valid", 32'(llc_valid), 32'd1);
            compare("bp_addr", llc_addr, 32'hD00D_0008);
            compare("bp_cmd", 32'(llc_cmd), 32'd8);
        end
        compare("bp_cnt", issued_cnt, 32'd18);
        idleTick(1'b1, 1'b0);
        idleTick(1'b0, 1'b1);
        compare("bp_cnt_inc", issued_cnt, 32'd19);

        // Random traffic with many illegal codes and random LLC timing.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of a WAIT cycle.
        doReset(0);
        applyStimulus(1'b1, 4'd9, 32'h5555_0000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        idleTick(1'b0, 1'b0);
        idleTick(1'b1, 1'b0);
        compare("pre_reset_wait", 32'(llc_valid), 32'd0);
        doReset(3);
        compare("rst_cmd", 32'(llc_cmd), 32'd0);
        compare("rst_addr", llc_addr, 32'd0);
        idleTick(1'b0, 1'b1);
        idleTick(1'b0, 1'b1);
        compare("rst_done_ignored", issued_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/llc_req_scheduler.md
# llc_req_scheduler

Synthesizable request scheduler in front of the LLC model. It accepts cache commands (trace-format command codes, 32-bit address) from a processor-side requester and a snoop-side requester and buffers each in its own FIFO. It issues them one at a time to the LLC over a valid/ready handshake and waits for completion before issuing the next. Arbitration gives the snoop side priority, with a starvation guard for the processor side.

## Interface
- CMDSIZE, 4, command code width
- ADDR_BITS, 32, address width
- FIFO_DEPTH, 4, entries per requester FIFO (power of two, ≥2)
- STARVE_LIMIT, 3, max consecutive snoop grants while CPU work is pending
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_valid  in  1  CPU request valid
- cpu_ready  out  1  CPU FIFO can accept (= !cpu_full)
- cpu_cmd  in  CMDSIZE  CPU command
- cpu_addr  in  ADDR_BITS  CPU address
- snp_valid / snp_ready / snp_cmd / snp_addr  in/out/in/in  1/1/CMDSIZE/ADDR_BITS  snoop requester, same rules as the CPU port
- llc_valid  out  1  command presented to LLC
- llc_ready  in  1  LLC accepts command
- llc_cmd  out  CMDSIZE  issued command
- llc_addr  out  ADDR_BITS  issued address
- llc_src  out  1  0 = CPU, 1 = snoop
- llc_done  in  1  single-cycle pulse: LLC finished the outstanding command
- cmd_err  out  1  single-cycle pulse: an illegal command was dropped
- issued_cnt  out  32  commands completed since reset

## Operation
- Legal codes: the CPU port takes 0, 1, 2, 8, 9; the snoop port takes 3, 4, 5, 6.
- Any other code on a port: the handshake completes (ready follows the normal rule), the entry is not enqueued, and cmd_err pulses the next cycle. If both ports drop an illegal command in the same cycle, cmd_err gives a single pulse.
- Push: valid && ready. ready depends only on full; a same-cycle pop does not raise ready.
- FSM states are IDLE, ISSUE, WAIT.
  - IDLE: if either FIFO is non-empty, pop the grant winner into the output registers and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: llc_valid=1, and cmd/addr/src are held stable. On llc_ready go to WAIT.
  - WAIT: on llc_done, increment issued_cnt and go to IDLE.
- llc_done outside WAIT is ignored.
- Arbitration in IDLE:
  - Only one FIFO non-empty: grant that FIFO.
  - Both non-empty: grant snoop unless starve_cnt == STARVE_LIMIT, in which case grant CPU.
- starve_cnt:
  - Increments on a snoop grant while the CPU FIFO is non-empty.
  - Clears on a CPU grant or whenever the CPU FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty on wrap.
- issued_cnt wraps from 0xFFFFFFFF to 0.
- Reset (asynchronous, any state): FIFOs empty, state IDLE, starve_cnt 0, issued_cnt 0, llc_valid 0, llc_cmd 0, llc_addr 0, llc_src 0, cmd_err 0, cpu_ready 1, snp_ready 1. A command in flight is abandoned; a later llc_done is ignored.

## Timing
- Enqueue to llc_valid, empty scheduler in IDLE: push at edge N, pop at edge N+1, llc_valid high after edge N+1 (2-cycle latency).
- llc_ready asserted in the first ISSUE cycle gives WAIT after the next edge. llc_done in the first WAIT cycle gives IDLE after the following edge.
- Minimum issue interval: 3 cycles per command (IDLE, ISSUE, WAIT).
- All outputs are registered except cpu_ready and snp_ready, which are combinational from the full flags.
- Back-pressure: llc_valid stays high indefinitely while llc_ready is low; there is no timeout.

## Test plan
- Reset then single CPU read: cpu cmd 0, addr 0x1000_0040.
  - llc_valid rises 2 cycles later with llc_src=0.
  - With ready=1 and done 1 cycle after ready, issued_cnt=1.
- Priority and starvation (STARVE_LIMIT=3): fill CPU with four cmd-1 entries and snoop with four cmd-4 entries, then complete everything immediately.
  - Required source order: S, S, S, C, S, C, C, C.
- Full and wrap: push 4 CPU commands with llc_ready=0.
  - cpu_ready=0 after the 4th; a 5th push is not accepted.
  - Drain, then push 4 more and confirm correct order across the pointer wrap.
- Illegal codes: cpu cmd 3, snoop cmd 1, cpu cmd 7 on separate cycles.
  - Each gives one cmd_err pulse and nothing is issued.
  - A simultaneous illegal cmd on both ports gives a single pulse.
- Back-pressure and stray done: hold llc_ready=0 for 10 cycles and pulse llc_done during ISSUE.
  - cmd/addr stay stable and issued_cnt is unchanged.
  - Then ready=1 and done=1 give issued_cnt+1.
- Reset mid-WAIT: deassert rst_n asynchronously mid-cycle.
  - All outputs return to reset values immediately.
  - A later llc_done leaves issued_cnt at 0.
